// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO word reader.
// Holds the control FSM encoding and packing defaults.
package fifo_rd_pkg;

  localparam int WORD_BYTES_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CLOSE = 2'd1,
    WAIT  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_word_reader_if.sv
// FIFO read port plus packed-word stream for the word reader.
// master = reader side, slave = FIFO/consumer side.
interface fifo_word_reader_if #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4
);

  logic                           fifo_empty;
  logic [DATA_W-1:0]              fifo_data;
  logic                           fifo_rd_en;
  logic                           flush;
  logic [DATA_W*WORD_BYTES-1:0]   m_data;
  logic [WORD_BYTES-1:0]          m_keep;
  logic                           m_last;
  logic                           m_valid;
  logic                           m_ready;

  modport master (
    input  fifo_empty, fifo_data, flush, m_ready,
    output fifo_rd_en, m_data, m_keep, m_last, m_valid
  );

  modport slave (
    output fifo_empty, fifo_data, flush, m_ready,
    input  fifo_rd_en, m_data, m_keep, m_last, m_valid
  );

endinterface

// File: rtl/word_pack_acc.sv
// Byte lane accumulator: lane registers, fill index, keep mask.
// clr empties the lanes; clr with wr restarts at lane 0.
module word_pack_acc #(
  parameter  int DATA_W     = 8,
  parameter  int WORD_BYTES = 4,
  localparam int IW         = $clog2(WORD_BYTES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic                         clr,
  input  logic [DATA_W-1:0]            din,
  output logic [IW-1:0]                idx,
  output logic [DATA_W*WORD_BYTES-1:0] data,
  output logic [WORD_BYTES-1:0]        keep,
  output logic                         full
);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      data <= '0;
    end else if (clr) begin
      data <= '0;
      if (wr) data[DATA_W-1:0] <= din;
      idx <= wr ? IW'(1) : '0;
    end else if (wr) begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (idx == IW'(i))
          data[i*DATA_W +: DATA_W] <= din;
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    keep = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      keep[i] = IW'(i) < idx;
  end

  assign full = idx == IW'(WORD_BYTES);

endmodule

// File: rtl/fifo_word_reader.sv
// Packs FIFO bytes into words; partial words close on
// flush or idle timeout and are tagged with m_last.
module fifo_word_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  fifo_word_reader_if.master  bus,
  output logic [15:0]         words_out
);

  localparam int IW = $clog2(WORD_BYTES + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  rd_state_t                    state;
  logic                         flush_pend;
  logic [CW-1:0]                idle;
  logic [IW-1:0]                acc_idx;
  logic [DATA_W*WORD_BYTES-1:0] acc_data;
  logic [WORD_BYTES-1:0]        acc_keep;
  logic                         acc_full;

  logic slot_free;
  logic have_part;
  logic close_req;
  logic full_xfer;
  logic part_xfer;
  logic rd_en;

  assign slot_free = !bus.m_valid || bus.m_ready;
  assign have_part = (acc_idx != '0) && !acc_full;
  assign close_req = (state == FILL) && have_part &&
                     ((flush_pend && bus.fifo_empty) || idle == TO);
  assign full_xfer = acc_full && slot_free;
  assign part_xfer = (state == CLOSE) && slot_free;

  // A full word may take a new byte only while it moves out.
  assign rd_en = !reset && !bus.fifo_empty &&
                 (state != CLOSE) && !close_req &&
                 (!acc_full || full_xfer);

  assign bus.fifo_rd_en = rd_en;

  word_pack_acc #(
    .DATA_W     (DATA_W),
    .WORD_BYTES (WORD_BYTES)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .wr    (rd_en),
    .clr   (full_xfer || part_xfer),
    .din   (bus.fifo_data),
    .idx   (acc_idx),
    .data  (acc_data),
    .keep  (acc_keep),
    .full  (acc_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      flush_pend  <= 1'b0;
      idle        <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_keep  <= '0;
      bus.m_last  <= 1'b0;
      words_out   <= '0;
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        bus.m_valid <= 1'b0;
        words_out   <= words_out + 16'd1;
      end

      if (full_xfer) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= acc_data;
        bus.m_keep  <= '1;
        bus.m_last  <= 1'b0;
      end else if (part_xfer) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= acc_data;
        bus.m_keep  <= acc_keep;
        bus.m_last  <= 1'b1;
      end

      if (part_xfer ||
          (state == FILL && flush_pend &&
           bus.fifo_empty && acc_idx == '0))
        flush_pend <= 1'b0;
      // A request arriving while one is pending is absorbed.
      if (bus.flush && !flush_pend)
        flush_pend <= 1'b1;

      if (state == FILL && have_part && !rd_en)
        idle <= (idle == TO) ? idle : idle + 1'b1;
      else
        idle <= '0;

      unique case (state)
        FILL: begin
          if (close_req)
            state <= CLOSE;
          else if (acc_full && !slot_free)
            state <= WAIT;
        end
        WAIT:    if (slot_free) state <= FILL;
        CLOSE:   if (slot_free) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Self-checking bench for fifo_word_reader: vector table,
// corner sequences and a randomized byte-stream scoreboard.
module tb_fifo_word_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] words_out;

  always #5 clk = ~clk;

  fifo_word_reader_if #(.DATA_W(8), .WORD_BYTES(4)) bus();

  fifo_word_reader #(
    .DATA_W     (8),
    .WORD_BYTES (4),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .words_out (words_out)
  );

  typedef struct {
    int          n;
    logic [63:0] b;
    bit          fl;
    int          nw;
    logic [36:0] w0;
    logic [36:0] w1;
    bit          to;
  } vec_t;

  int          nvec = 0;
  int          nerr = 0;
  logic [7:0]  src[$];
  logic [7:0]  exp_q[$];
  logic [36:0] got[$];
  int          pop_t[$];
  int          acc_t[$];
  int          tcount = 0;
  int          rnd_acc = 0;
  bit          gap = 0, rdy = 1, fl = 0, rst = 1, rnd = 0;
  bit          prev_hold = 0;
  logic [36:0] prev_o = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic        pop, acc, l_e;
    logic [36:0] o;
    logic [31:0] w;
    int          n;
    reset          = rst;
    bus.flush      = fl;
    bus.m_ready    = rdy;
    bus.fifo_empty = gap || (src.size() == 0);
    bus.fifo_data  = (src.size() != 0) ? src[0] : 8'h00;
    #2;
    pop = bus.fifo_rd_en;
    acc = bus.m_valid && bus.m_ready;
    o   = {bus.m_data, bus.m_keep, bus.m_last};
    chk("rd_when_empty", 64'(pop && bus.fifo_empty), 64'd0);
    if (rst) chk("rd_in_reset", 64'(pop), 64'd0);
    if (prev_hold && !rst)
      chk("hold", 64'({bus.m_valid, o}), 64'({1'b1, prev_o}));
    prev_hold = bus.m_valid && !bus.m_ready && !rst;
    prev_o    = o;
    @(posedge clk);
    #1;
    if (pop && src.size() != 0) begin
      src.delete(0);
      pop_t.push_back(tcount);
    end
    if (acc) begin
      got.push_back(o);
      acc_t.push_back(tcount);
      if (rnd) begin
        n = (exp_q.size() >= 4) ? 4 : exp_q.size();
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = exp_q.pop_front();
        l_e = (n < 4);
        chk("rnd_word", 64'(o), 64'({w, 4'((1 << n) - 1), l_e}));
        rnd_acc++;
      end
    end
    tcount++;
    @(negedge clk);
  endtask

  task automatic clear_rec();
    got.delete();
    pop_t.delete();
    acc_t.delete();
    tcount = 0;
  endtask

  task automatic do_reset();
    rst = 1; fl = 0; gap = 0; rdy = 1;
    src.delete();
    tick();
    tick();
    rst = 0;
    clear_rec();
  endtask

  initial begin
    vec_t       tbl[6];
    logic [7:0] b;
    int         run;
    int         lat;
    int         n;

    tbl[0] = '{8, 64'h0807060504030201, 1'b0, 2,
               {32'h04030201, 4'hF, 1'b0},
               {32'h08070605, 4'hF, 1'b0}, 1'b0};
    tbl[1] = '{2, 64'hBBAA, 1'b1, 1,
               {32'h0000BBAA, 4'h3, 1'b1}, 37'd0, 1'b0};
    tbl[2] = '{1, 64'h5C, 1'b0, 1,
               {32'h0000005C, 4'h1, 1'b1}, 37'd0, 1'b1};
    tbl[3] = '{0, 64'h0, 1'b1, 0, 37'd0, 37'd0, 1'b0};
    tbl[4] = '{3, 64'h332211, 1'b1, 1,
               {32'h00332211, 4'h7, 1'b1}, 37'd0, 1'b0};
    tbl[5] = '{5, 64'h0504030201, 1'b1, 2,
               {32'h04030201, 4'hF, 1'b0},
               {32'h00000005, 4'h1, 1'b1}, 1'b0};

    @(negedge clk);
    do_reset();
    chk("reset_outs", 64'({bus.m_valid, bus.m_last, bus.m_keep,
                          bus.m_data, words_out}), 64'd0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      n = tbl[v].n;
      for (int i = 0; i < n; i++) src.push_back(tbl[v].b[8*i +: 8]);
      repeat (n + 2) tick();
      if (tbl[v].fl) begin
        fl = 1; tick(); fl = 0;
      end
      repeat (30) tick();
      chk($sformatf("words[%0d]", v), 64'(got.size()), 64'(tbl[v].nw));
      chk($sformatf("words_out[%0d]", v), 64'(words_out), 64'(tbl[v].nw));
      if (tbl[v].nw > 0 && got.size() > 0)
        chk($sformatf("word0[%0d]", v), 64'(got[0]), 64'(tbl[v].w0));
      if (tbl[v].nw > 1 && got.size() > 1)
        chk($sformatf("word1[%0d]", v), 64'(got[1]), 64'(tbl[v].w1));
      if (n > 0) begin
        chk($sformatf("pops[%0d]", v), 64'(pop_t.size()), 64'(n));
        if (pop_t.size() == n)
          chk($sformatf("pop_span[%0d]", v),
              64'(pop_t[n-1] - pop_t[0]), 64'(n - 1));
      end
      if (tbl[v].to && acc_t.size() > 0 && pop_t.size() > 0) begin
        lat = acc_t[0] - pop_t[pop_t.size()-1];
        chk("timeout_lat", 64'(lat >= 17 && lat <= 21), 64'd1);
      end
    end

    // back-pressure: first word held, no reads while full
    do_reset();
    rdy = 0;
    for (int i = 0; i < 4; i++) src.push_back(8'h11 + 8'(i));
    repeat (5) tick();
    chk("bp_valid", 64'(bus.m_valid), 64'd1);
    for (int i = 0; i < 5; i++) src.push_back(8'h15 + 8'(i));
    repeat (6) tick();
    chk("bp_no_read", 64'(src.size()), 64'd1);
    chk("bp_data", 64'(bus.m_data), 64'h14131211);
    rdy = 1;
    repeat (8) tick();
    chk("bp_words", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      chk("bp_w0", 64'(got[0]), 64'({32'h14131211, 4'hF, 1'b0}));
      chk("bp_w1", 64'(got[1]), 64'({32'h18171615, 4'hF, 1'b0}));
    end

    // reset mid-word discards the partial word
    do_reset();
    for (int i = 1; i <= 3; i++) src.push_back(8'(i));
    repeat (3) tick();
    for (int i = 0; i < 4; i++) src.push_back(8'h21 + 8'(i));
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_outs", 64'({bus.m_valid, bus.m_last, bus.m_keep,
                            bus.m_data, words_out}), 64'd0);
    chk("mid_rst_nopop", 64'(src.size()), 64'd4);
    clear_rec();
    repeat (10) tick();
    chk("mid_rst_words", 64'(got.size()), 64'd1);
    if (got.size() > 0)
      chk("mid_rst_w0", 64'(got[0]), 64'({32'h24232221, 4'hF, 1'b0}));

    // flush with nothing accumulated leaves no pending request
    do_reset();
    fl = 1; tick(); fl = 0;
    repeat (3) tick();
    chk("empty_flush", 64'(got.size()), 64'd0);
    src.push_back(8'h77);
    repeat (6) tick();
    chk("flag_cleared", 64'(got.size()), 64'd0);
    fl = 1; tick(); fl = 0;
    repeat (5) tick();
    chk("late_flush_n", 64'(got.size()), 64'd1);
    if (got.size() > 0)
      chk("late_flush_w", 64'(got[0]), 64'({32'h00000077, 4'h1, 1'b1}));

    // random stream against a byte-order scoreboard
    do_reset();
    exp_q.delete();
    rnd = 1;
    rnd_acc = 0;
    run = 0;
    for (int c = 0; c < 600; c++) begin
      if (src.size() < 6)
        repeat ($urandom_range(2, 1)) begin
          b = 8'($urandom);
          src.push_back(b);
          exp_q.push_back(b);
        end
      gap = (run < 3) && ($urandom_range(3) == 0);
      run = gap ? run + 1 : 0;
      rdy = ($urandom_range(9) < 7);
      tick();
    end
    gap = 0;
    rdy = 1;
    for (int i = 0; i < 60 && src.size() != 0; i++) tick();
    chk("rnd_drain", 64'(src.size()), 64'd0);
    fl = 1; tick(); fl = 0;
    repeat (12) tick();
    chk("rnd_left", 64'(exp_q.size()), 64'd0);
    chk("rnd_count", 64'(words_out), 64'(16'(rnd_acc)));
    rnd = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_word_reader.md
FIFO_WORD_READER -- requirements
Module: fifo_word_reader

Interface
REQ-001 Parameter DATA_W, default 8, FIFO byte width.
REQ-002 Parameter WORD_BYTES, default 4, bytes packed per output word.
REQ-003 Parameter TIMEOUT, default 16, idle cycles before a partial word is auto-flushed.
REQ-004 Port clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port fifo_empty, input, 1, FIFO has no readable byte.
REQ-007 Port fifo_data, input, DATA_W, FIFO read data; valid combinationally while fifo_rd_en is high.
REQ-008 Port fifo_rd_en, output, 1, read strobe; FIFO pops on the rising edge where it is high.
REQ-009 Port flush, input, 1, one-cycle request to emit the pending partial word.
REQ-010 Port m_data, output, DATA_W*WORD_BYTES, packed word.
REQ-011 Port m_keep, output, WORD_BYTES, valid-byte mask, bit i marks byte i.
REQ-012 Port m_last, output, 1, word closed by flush or timeout.
REQ-013 Port m_valid, output, 1, output word present.
REQ-014 Port m_ready, input, 1, downstream accepts the word.
REQ-015 Port words_out, output, 16, count of accepted words; wraps modulo 2^16.

Function
REQ-016 fifo_rd_en SHALL be high exactly when fifo_empty=0, no close is in progress, and the accumulator can accept a byte (index<WORD_BYTES, or full and transferring this cycle).
REQ-017 A byte read on edge N SHALL land in accumulator lane idx, lane 0 = bits [DATA_W-1:0], first byte in lane 0.
REQ-018 A full accumulator SHALL transfer to the output slot when the slot is empty or is being accepted (m_valid&m_ready) in the same cycle, with m_keep all ones and m_last=0.
REQ-019 Transfer SHALL be one cycle: the word is on m_data with m_valid=1 the cycle after its last byte is read, and back-to-back words SHALL sustain one byte per cycle with m_ready held high.
REQ-020 m_data, m_keep, m_last SHALL be stable while m_valid=1 and m_ready=0.
REQ-021 flush SHALL set a pending flag; once fifo_empty=1 and the accumulator holds k>=1 bytes, the partial word SHALL transfer with m_keep=(1<<k)-1, unused lanes zero, m_last=1.
REQ-022 Pending flush with an empty accumulator and fifo_empty=1 SHALL clear with no output.
REQ-023 An idle counter SHALL count cycles with k>=1 and no read, reset on any read; reaching TIMEOUT SHALL close the word exactly as REQ-021.
REQ-024 flush arriving while a flush is pending SHALL be absorbed (no second word).
REQ-025 words_out SHALL increment on every cycle with m_valid&m_ready.
REQ-026 Control FSM states: FILL (reading), CLOSE (partial transfer pending on slot), WAIT (accumulator full, slot busy); FILL->WAIT on full with busy slot, WAIT->FILL on transfer, FILL->CLOSE on flush/timeout condition, CLOSE->FILL on transfer.

Reset
REQ-027 With reset high on an edge, fifo_rd_en, m_valid, m_last, m_keep, m_data, words_out, accumulator index, idle counter, flush flag SHALL be 0 and FSM SHALL be FILL.
REQ-028 Reset mid-word SHALL discard accumulated bytes and the output slot without emitting them.
REQ-029 fifo_rd_en SHALL be 0 in every cycle reset is high.

Structure
REQ-030 Package fifo_rd_pkg SHALL hold the FSM state encoding and default WORD_BYTES/TIMEOUT constants.
REQ-031 One sub-module, word_pack_acc, SHALL hold lane registers, byte index and keep generation; FSM, output slot and counters stay in the top.

Verification
REQ-032 FIFO bytes 01..08, m_ready=1 -> words 0x04030201, 0x08070605, m_keep=4'hF, m_last=0, words_out=2, no idle bubbles.
REQ-033 Bytes 11..14 with m_ready=0 for 5 cycles, then 15..18 available -> first word stable, fifo_rd_en=0 while accumulator full, 0x18171615 follows.
REQ-034 Bytes AA,BB then fifo_empty, flush pulse -> m_data=0x0000BBAA, m_keep=4'h3, m_last=1.
REQ-035 Byte 5C then fifo_empty, no flush -> after 16 idle cycles m_data=0x0000005C, m_keep=4'h1, m_last=1.
REQ-036 Reset asserted after 3 bytes of a word -> all outputs 0, next bytes 21..24 give 0x24232221.
REQ-037 Flush with accumulator empty and FIFO empty -> no m_valid, flag cleared.
